// File: rtl/hub75_bcm_scan_tx.sv
// hub75_bcm_scan_tx
//   Autonomous HUB75 frame scanner with binary-coded-modulation refresh.
//   For each row and each bit plane (MSB first) it shifts one plane of pixel
//   bits out of frame memory, blanks, drives the row address, latches, and
//   then enables the panel for i_oe_base << plane cycles. The shift of the
//   next plane runs while the current plane is being displayed.
//
//   Optional feature macro: HUB75_BRIGHTNESS_EN
//     When defined, adds i_brightness[7:0]. It is sampled at frame start, and
//     the display time becomes ((i_oe_base << plane) * brightness) >> 8.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_enable            run continuous frames while high
//   i_clk_div           serial clock period in clk cycles (values < 2 act as 2)
//   i_oe_base           plane-0 display time in clk cycles
//   o_busy              high from frame start to frame end
//   o_frame_done        one-cycle pulse when a frame has been fully displayed
//   o_rd_addr           frame memory address, row*hpixel_p + column
//   i_rd_data           [seg][R,G,B][bit] pixel data, 1 clk after o_rd_addr
//   o_serial_clk        panel shift clock
//   o_red/green/blue    serial data, one bit per segment
//   o_latch_en          panel latch
//   o_oe_n              panel output enable, active-low
//   o_row               panel row address
module hub75_bcm_scan_tx #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 64,
  parameter int bpp_p        = 8,
  parameter int segments_p   = 2,
  parameter int clk_div_wd_p = 8,
  parameter int oe_base_wd_p = 16,
  parameter int rows_p       = vpixel_p / segments_p,
  parameter int row_wd_p     = $clog2(rows_p),
  parameter int addr_width_p = $clog2(rows_p * hpixel_p),
  parameter int oe_cnt_wd_p  = oe_base_wd_p + bpp_p
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_enable,
  input  logic [clk_div_wd_p-1:0]           i_clk_div,
  input  logic [oe_base_wd_p-1:0]           i_oe_base,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                        i_brightness,
`endif
  output logic                              o_busy,
  output logic                              o_frame_done,
  output logic [addr_width_p-1:0]           o_rd_addr,
  input  logic [segments_p*3*bpp_p-1:0]     i_rd_data,
  output logic                              o_serial_clk,
  output logic [segments_p-1:0]             o_red,
  output logic [segments_p-1:0]             o_green,
  output logic [segments_p-1:0]             o_blue,
  output logic                              o_latch_en,
  output logic                              o_oe_n,
  output logic [row_wd_p-1:0]               o_row
);

  localparam int col_wd_lp   = $clog2(hpixel_p);
  localparam int plane_wd_lp = (bpp_p > 1) ? $clog2(bpp_p) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_OE, BLANK, LATCH, DONE} state_t;

  state_t                    state_q, state_d;
  logic [clk_div_wd_p-1:0]   div_q, div_d;
  logic [oe_base_wd_p-1:0]   base_q, base_d;
  logic [row_wd_p-1:0]       row_q, row_d;
  logic [plane_wd_lp-1:0]    plane_q, plane_d;
  logic [col_wd_lp-1:0]      col_q, col_d;
  logic [clk_div_wd_p-1:0]   ph_q, ph_d;
  logic [1:0]                lead_q, lead_d;
  logic [oe_cnt_wd_p-1:0]    oe_cnt_q, oe_cnt_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [addr_width_p-1:0]   rd_addr_q, rd_addr_d;
  logic                      sclk_q, sclk_d;
  logic [segments_p-1:0]     red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                      latch_q, latch_d;
  logic                      oe_n_q, oe_n_d;
  logic [row_wd_p-1:0]       orow_q, orow_d;
  logic                      start;
  logic                      load_pix;
  logic [oe_cnt_wd_p-1:0]    shifted;
  logic [oe_cnt_wd_p-1:0]    load_val;

  function automatic logic [clk_div_wd_p-1:0] clamp_div(input logic [clk_div_wd_p-1:0] v);
    return (v < clk_div_wd_p'(2)) ? clk_div_wd_p'(2) : v;
  endfunction

  function automatic logic [addr_width_p-1:0] addr_of(input logic [row_wd_p-1:0] r,
                                                      input logic [col_wd_lp-1:0] c);
    return (addr_width_p'(r) << col_wd_lp) | addr_width_p'(c);
  endfunction

  assign shifted = oe_cnt_wd_p'(base_q) << plane_q;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]               bri_q, bri_d;
  logic [oe_cnt_wd_p+7:0]   prod;
  assign prod     = {8'd0, shifted} * {{oe_cnt_wd_p{1'b0}}, bri_q};
  assign load_val = prod[oe_cnt_wd_p+7:8];
`else
  assign load_val = shifted;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    base_d    = base_q;
    row_d     = row_q;
    plane_d   = plane_q;
    col_d     = col_q;
    ph_d      = ph_q;
    lead_d    = lead_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    sclk_d    = sclk_q;
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    latch_d   = latch_q;
    orow_d    = orow_q;
    start     = 1'b0;
    load_pix  = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    bri_d     = bri_q;
`endif
    // The display counter free-runs down to zero in every state.
    oe_cnt_d  = (oe_cnt_q != '0) ? oe_cnt_q - oe_cnt_wd_p'(1) : '0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_enable) start = 1'b1;
      end
      SHIFT: begin
        // Two lead cycles cover address register + memory read latency
        // before column 0 data can be registered onto the pins.
        if (lead_q == 2'd2) begin
          lead_d = 2'd1;
        end else if (lead_q == 2'd1) begin
          lead_d   = 2'd0;
          col_d    = '0;
          ph_d     = '0;
          sclk_d   = 1'b0;
          load_pix = 1'b1;
          if (hpixel_p > 1) rd_addr_d = addr_of(row_q, col_wd_lp'(1));
        end else if (ph_q == div_q - clk_div_wd_p'(1)) begin
          sclk_d = 1'b0;
          if (col_q == col_wd_lp'(hpixel_p - 1)) begin
            state_d = WAIT_OE;
          end else begin
            // Address for column+1 has been held for a whole bit, so
            // i_rd_data now carries it; prefetch column+2 next.
            col_d    = col_q + col_wd_lp'(1);
            ph_d     = '0;
            load_pix = 1'b1;
            if (int'(col_q) + 2 < hpixel_p)
              rd_addr_d = addr_of(row_q, col_q + col_wd_lp'(2));
          end
        end else begin
          ph_d   = ph_q + clk_div_wd_p'(1);
          sclk_d = ((ph_q + clk_div_wd_p'(1)) >= (div_q >> 1));
        end
      end
      WAIT_OE: begin
        if (oe_cnt_q == '0) state_d = BLANK;
      end
      BLANK: begin
        orow_d  = row_q;
        latch_d = 1'b1;
        ph_d    = '0;
        state_d = LATCH;
      end
      LATCH: begin
        if (ph_q == div_q - clk_div_wd_p'(1)) begin
          latch_d  = 1'b0;
          oe_cnt_d = load_val;
          if (plane_q != '0) begin
            plane_d   = plane_q - plane_wd_lp'(1);
            lead_d    = 2'd2;
            rd_addr_d = addr_of(row_q, '0);
            state_d   = SHIFT;
          end else if (row_q != row_wd_p'(rows_p - 1)) begin
            row_d     = row_q + row_wd_p'(1);
            plane_d   = plane_wd_lp'(bpp_p - 1);
            lead_d    = 2'd2;
            rd_addr_d = addr_of(row_q + row_wd_p'(1), '0);
            state_d   = SHIFT;
          end else begin
            state_d = DONE;
          end
        end else begin
          ph_d = ph_q + clk_div_wd_p'(1);
        end
      end
      DONE: begin
        if (oe_cnt_q == '0) begin
          done_d = 1'b1;
          if (i_enable) begin
            start = 1'b1;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      div_d     = clamp_div(i_clk_div);
      base_d    = i_oe_base;
`ifdef HUB75_BRIGHTNESS_EN
      bri_d     = i_brightness;
`endif
      row_d     = '0;
      plane_d   = plane_wd_lp'(bpp_p - 1);
      busy_d    = 1'b1;
      lead_d    = 2'd2;
      rd_addr_d = '0;
      state_d   = SHIFT;
    end

    if (load_pix) begin
      for (int s = 0; s < segments_p; s++) begin
        red_d[s]   = i_rd_data[s*3*bpp_p + 2*bpp_p + int'(plane_q)];
        green_d[s] = i_rd_data[s*3*bpp_p + bpp_p + int'(plane_q)];
        blue_d[s]  = i_rd_data[s*3*bpp_p + int'(plane_q)];
      end
    end

    oe_n_d = (oe_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= clk_div_wd_p'(2);
      base_q    <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      col_q     <= '0;
      ph_q      <= '0;
      lead_q    <= '0;
      oe_cnt_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= '0;
      sclk_q    <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      latch_q   <= 1'b0;
      oe_n_q    <= 1'b1;
      orow_q    <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bri_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      base_q    <= base_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      col_q     <= col_d;
      ph_q      <= ph_d;
      lead_q    <= lead_d;
      oe_cnt_q  <= oe_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      sclk_q    <= sclk_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      latch_q   <= latch_d;
      oe_n_q    <= oe_n_d;
      orow_q    <= orow_d;
`ifdef HUB75_BRIGHTNESS_EN
      bri_q     <= bri_d;
`endif
    end
  end

  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_serial_clk = sclk_q;
  assign o_red        = red_q;
  assign o_green      = green_q;
  assign o_blue       = blue_q;
  assign o_latch_en   = latch_q;
  assign o_oe_n       = oe_n_q;
  assign o_row        = orow_q;

endmodule

// File: doc/hub75_bcm_scan_tx.md
Name: hub75_bcm_scan_tx

Overview:
- Autonomous HUB75 frame scanner. Replaces single-row, single-bit-plane transmit with a full binary-coded-modulation (BCM) refresh.
- For every row and every bit plane it:
  - shifts pixel bits out of frame memory,
  - latches them,
  - drives the row address,
  - enables output for a time weighted by bit significance.
- The shift of plane p-1 overlaps the display of plane p.
- Sits between the frame buffer read port and the panel pins.

Parameters:
- hpixel_p, 64, display width in pixels (power of 2)
- vpixel_p, 64, display height in pixels
- bpp_p, 8, bits per colour channel (= bit planes)
- segments_p, 2, panel segments driven in parallel; rows_p = vpixel_p/segments_p
- clk_div_wd_p, 8, width of serial clock divider
- oe_base_wd_p, 16, width of LSB-plane display time
- Derived: row_wd_p = $clog2(rows_p); addr_width_p = $clog2(rows_p*hpixel_p); oe_cnt_wd_p = oe_base_wd_p+bpp_p

Ports:
- clk  in  1  clock; everything synchronous to rising edge
- rst  in  1  synchronous reset, active-high
- i_enable  in  1  level; run continuous frames while high
- i_clk_div  in  clk_div_wd_p  serial clock period in clk cycles; values <2 treated as 2
- i_oe_base  in  oe_base_wd_p  plane-0 display time in clk cycles
- o_busy  out  1  high from frame start to frame end
- o_frame_done  out  1  one-cycle pulse after last plane of last row displayed
- o_rd_addr  out  addr_width_p  row*hpixel_p + column
- i_rd_data  in  segments_p x 3 x bpp_p  [seg][2=R,1=G,0=B][bit]; valid 1 clk after o_rd_addr
- o_serial_clk  out  1  panel shift clock
- o_red, o_green, o_blue  out  segments_p each  serial data per segment
- o_latch_en  out  1  panel latch
- o_oe_n  out  1  output enable, active-low
- o_row  out  row_wd_p  panel row address

Behaviour:
- Reset: all outputs 0 except o_oe_n=1; state IDLE; counters cleared. Reset mid-frame aborts immediately; o_oe_n=1 in the cycle after rst is sampled.
- States: IDLE, SHIFT, WAIT_OE, BLANK, LATCH, DONE.
- IDLE:
  - o_busy=0.
  - i_enable=1: sample i_clk_div (clamped) and i_oe_base into internal registers, row=0, plane=bpp_p-1, o_busy=1, go to SHIFT.
  - Sampled values hold for the whole frame.
- SHIFT: hpixel_p bits per plane, columns 0..hpixel_p-1.
  - Per bit: o_serial_clk low for div/2 cycles, high for div-div/2 cycles.
  - Data changes only during the low phase. It is stable at least 1 clk before the rising edge and held through the high phase.
  - Data = i_rd_data[s][c][plane]. o_rd_addr advances early enough to meet the 1-clk read latency.
  - After the last bit: o_serial_clk=0, go to WAIT_OE.
- WAIT_OE: wait until the display counter is 0. That counter reaches 0 when the previous plane finishes; it is already 0 for the first plane of the frame.
- BLANK:
  - o_oe_n=1 for 1 clk; o_row <= current row.
  - Next state LATCH.
- LATCH:
  - o_latch_en=1 for exactly div cycles, o_oe_n stays 1.
  - On exit: load display counter with i_oe_base<<plane, zero-extended to oe_cnt_wd_p.
  - o_oe_n=0 while the counter is nonzero; the counter decrements every clk.
- Plane/row advance after LATCH:
  - plane>0: plane-1, go to SHIFT (overlaps display).
  - plane==0 and row<rows_p-1: row+1, plane=bpp_p-1, go to SHIFT.
  - Otherwise go to DONE.
- DONE:
  - Wait for the display counter to reach 0, then o_oe_n=1.
  - o_frame_done=1 for 1 clk.
  - i_enable=1: resample config, restart at row 0 in the next cycle.
  - Otherwise go to IDLE.
- i_enable falling mid-frame has no effect until DONE; the frame always completes.
- oe_base=0: counter loads 0, o_oe_n never goes low; the sequence is otherwise unchanged.
- Counter arithmetic never wraps; oe_cnt_wd_p is sized for the maximum shift.
- Config inputs changing mid-frame are ignored.

Optional Feature:
- Macro HUB75_BRIGHTNESS_EN.
- Defined:
  - Adds port i_brightness in 8, sampled at frame start with the other config.
  - Display counter load = ((i_oe_base<<plane) * brightness) >> 8.
  - brightness=0 keeps the display blanked.
- Undefined:
  - Port absent; load = i_oe_base<<plane, i.e. full brightness.

Test Plan (hpixel_p=4, vpixel_p=4, bpp_p=2, segments_p=2 unless stated):
- Reset, then rst=0 with i_enable=0 -> o_oe_n=1; all other outputs 0; o_busy=0 indefinitely.
- i_clk_div=4, i_oe_base=10, one frame -> 4 rising edges of o_serial_clk per plane, 16 total. Per plane o_serial_clk is low 2 clk and high 2 clk per bit. o_latch_en pulses 4 clk, 4 times in total. Plane1 o_oe_n low 20 clk, plane0 low 10 clk. o_frame_done pulses once.
- Memory model returning data = address (R/G/B bits distinct per segment) -> serial bits match i_rd_data[s][c][plane] for each column. o_row = 0 then 1. o_rd_addr stays within 0..7.
- i_clk_div=1 -> behaves identically to i_clk_div=2.
- i_oe_base=0 -> o_oe_n stays 1 all frame; latch and frame_done timing unchanged.
- i_enable dropped mid-frame -> frame completes, o_frame_done pulses, then IDLE. rst asserted mid-SHIFT -> o_oe_n=1 and outputs return to reset values in the next cycle.
